// File: rtl/inst_mem_loader_if.sv
// inst_mem_loader_if: host-side and memory-side signals of the instruction loader.
//   start, rx_data, rx_valid : session control and UART byte stream into the loader
//   mem_we, mem_addr, mem_wdata : instruction-memory write port out of the loader
//   core_rst, busy, done, error, words_loaded : status out of the loader
//   master modport is the loader; slave modport is its environment.
interface inst_mem_loader_if;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        core_rst;
    logic        busy;
    logic        done;
    logic        error;
    logic [8:0]  words_loaded;
    modport master (
        input  start, rx_data, rx_valid,
        output mem_we, mem_addr, mem_wdata, core_rst, busy, done, error, words_loaded
    );
    modport slave (
        output start, rx_data, rx_valid,
        input  mem_we, mem_addr, mem_wdata, core_rst, busy, done, error, words_loaded
    );
endinterface

// File: rtl/inst_mem_loader.sv
// inst_mem_loader: loads a length-prefixed, XOR-checksummed byte stream into instruction memory.
//   clk_in : clock, all state on rising edge
//   rst    : synchronous active-low reset
//   bus    : inst_mem_loader_if.master (byte stream in, memory write port and status out)
module inst_mem_loader #(
    parameter int MAX_WORDS = 256,
    parameter int TIMEOUT   = 1_000_000
) (
    input logic clk_in,
    input logic rst,
    inst_mem_loader_if.master bus
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CHK, DONE, ERR} state_t;
    state_t state_q, state_d;
    logic [15:0] n_q, n_d;
    logic [1:0] idx_q, idx_d;
    logic [31:0] word_q, word_d;
    logic [7:0] chk_q, chk_d;
    logic pend_q, pend_d;
    logic we_q, we_d;
    logic [9:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [8:0] wl_q, wl_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic busy_q, busy_d, done_q, done_d, err_q, err_d, crst_q, crst_d;
    logic in_busy;
    always_comb begin
        in_busy = state_q inside {LEN0, LEN1, DATA, CHK};
        state_d = state_q;
        n_d = n_q;
        idx_d = idx_q;
        word_d = word_q;
        chk_d = chk_q;
        pend_d = 1'b0;
        // a completed word is written one cycle after it is assembled, so a
        // reset in that cycle can still cancel the write
        we_d = pend_q;
        addr_d = pend_q ? {wl_q[7:0], 2'b00} : addr_q;
        wdata_d = pend_q ? word_q : wdata_q;
        wl_d = we_q ? wl_q + 9'd1 : wl_q;
        tmo_d = (in_busy && !bus.rx_valid) ? tmo_q + 1'b1 : '0;
        case (state_q)
            IDLE, DONE, ERR: if (bus.start) begin
                state_d = LEN0;
                n_d = '0;
                idx_d = '0;
                word_d = '0;
                chk_d = '0;
                wl_d = '0;
                addr_d = '0;
                tmo_d = '0;
            end
            LEN0: if (bus.rx_valid) begin
                n_d[7:0] = bus.rx_data;
                state_d = LEN1;
            end
            LEN1: if (bus.rx_valid) begin
                n_d[15:8] = bus.rx_data;
                state_d = (n_d == 16'd0 || n_d > 16'(MAX_WORDS)) ? ERR : DATA;
            end
            DATA: if (bus.rx_valid) begin
                word_d[{idx_q, 3'b000} +: 8] = bus.rx_data;
                chk_d = chk_q ^ bus.rx_data;
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    pend_d = 1'b1;
                    // wl_q still excludes this word; its write has not happened yet
                    if ({7'd0, wl_q} + 16'd1 == n_q) state_d = CHK;
                end
            end
            CHK: if (bus.rx_valid) state_d = (bus.rx_data == chk_q) ? DONE : ERR;
            default: state_d = state_q;
        endcase
        if (in_busy && tmo_d == TW'(TIMEOUT)) state_d = ERR;
        busy_d = state_d inside {LEN0, LEN1, DATA, CHK};
        done_d = state_d == DONE;
        err_d = state_d == ERR;
        crst_d = busy_d || err_d;
    end
    always_ff @(posedge clk_in) begin
        if (!rst) begin
            state_q <= IDLE;
            n_q <= '0;
            idx_q <= '0;
            word_q <= '0;
            chk_q <= '0;
            pend_q <= 1'b0;
            we_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            wl_q <= '0;
            tmo_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q <= 1'b0;
            crst_q <= 1'b0;
        end else begin
            state_q <= state_d;
            n_q <= n_d;
            idx_q <= idx_d;
            word_q <= word_d;
            chk_q <= chk_d;
            pend_q <= pend_d;
            we_q <= we_d;
            addr_q <= addr_d;
            wdata_q <= wdata_d;
            wl_q <= wl_d;
            tmo_q <= tmo_d;
            busy_q <= busy_d;
            done_q <= done_d;
            err_q <= err_d;
            crst_q <= crst_d;
        end
    end
    assign bus.mem_we = we_q;
    assign bus.mem_addr = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.core_rst = crst_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.error = err_q;
    assign bus.words_loaded = wl_q;
endmodule

// File: tb/tb_inst_mem_loader.sv
// tb_inst_mem_loader: scoreboard bench for inst_mem_loader with directed byte streams.
module tb_inst_mem_loader;
    localparam int TMO = 40;
    logic clk_in = 1'b0;
    logic rst = 1'b0;
    inst_mem_loader_if bus();
    inst_mem_loader #(.MAX_WORDS(256), .TIMEOUT(TMO)) dut (.clk_in(clk_in), .rst(rst), .bus(bus.master));
    always #5 clk_in = ~clk_in;
    int total = 0;
    int bad = 0;
    int writes = 0;
    logic [41:0] exp_q[$];
    logic [41:0] e;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        bus.rx_data = b;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        tick(1);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
    endtask

    task automatic strt;
        bus.start = 1'b1;
        tick(1);
        bus.start = 1'b0;
    endtask

    task automatic do_reset;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic push(input logic [9:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_we"}, {31'd0, bus.mem_we}, 32'd0);
        check({tag, "_addr"}, {22'd0, bus.mem_addr}, 32'd0);
        check({tag, "_wdata"}, bus.mem_wdata, 32'd0);
        check({tag, "_status"}, {28'd0, bus.busy, bus.done, bus.error, bus.core_rst}, 32'd0);
        check({tag, "_wl"}, {23'd0, bus.words_loaded}, 32'd0);
    endtask

    task automatic two_word_stream(input logic [7:0] cs);
        push(10'd0, 32'h00500013);
        push(10'd4, 32'h40A500B3);
        send(8'h02);
        send(8'h00);
        send_word(32'h00500013);
        send_word(32'h40A500B3);
        send(cs);
        tick(2);
    endtask

    always @(negedge clk_in) begin
        if (bus.mem_we === 1'b1) begin
            writes++;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want no write", bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", {22'd0, bus.mem_addr}, {22'd0, e[41:32]});
                check("wr_data", bus.mem_wdata, e[31:0]);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test want finish");
        $fatal(1);
    end

    initial begin
        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data = 8'h00;
        tick(3);
        check_reset("rst");
        rst = 1'b1;
        tick(1);
        // good two-word session; checksum is XOR of the eight data bytes = 0x15
        strt;
        check("s1_busy", {30'd0, bus.busy, bus.core_rst}, 32'h3);
        two_word_stream(8'h15);
        check("s1_done", {29'd0, bus.done, bus.error, bus.busy}, 32'h4);
        check("s1_wl", {23'd0, bus.words_loaded}, 32'd2);
        check("s1_core_rst", {31'd0, bus.core_rst}, 32'd0);
        check("s1_last_addr", {22'd0, bus.mem_addr}, 32'd4);
        check("s1_writes", writes, 32'd2);
        // bad checksum: words stay written, error holds the core
        strt;
        check("s2_wl_clear", {23'd0, bus.words_loaded}, 32'd0);
        two_word_stream(8'h00);
        check("s2_err", {29'd0, bus.done, bus.error, bus.core_rst}, 32'h3);
        check("s2_wl", {23'd0, bus.words_loaded}, 32'd2);
        send(8'hAA);
        check("s2_ignored", {22'd0, bus.error, bus.words_loaded}, {22'd0, 1'b1, 9'd2});
        check("s2_writes", writes, 32'd4);
        // length limits
        strt;
        check("s3_core_rst", {31'd0, bus.core_rst}, 32'd1);
        send(8'h00);
        send(8'h00);
        check("s3_n0", {30'd0, bus.error, bus.busy}, 32'h2);
        strt;
        send(8'h01);
        send(8'h01);
        check("s3_n257", {30'd0, bus.error, bus.busy}, 32'h2);
        strt;
        send(8'h00);
        send(8'h01);
        check("s3_n256", {30'd0, bus.error, bus.busy}, 32'h1);
        check("s3_writes", writes, 32'd4);
        do_reset;
        check_reset("s3_rst");
        // inter-byte timeout
        strt;
        send(8'h01);
        send(8'h00);
        send(8'h11);
        send(8'h22);
        tick(TMO - 8);
        check("s4_before", {30'd0, bus.error, bus.busy}, 32'h1);
        tick(12);
        check("s4_after", {30'd0, bus.error, bus.busy}, 32'h2);
        check("s4_writes", writes, 32'd4);
        // reset in the cycle after the fourth data byte cancels the write
        strt;
        send(8'h01);
        send(8'h00);
        send(8'hDE);
        send(8'hAD);
        send(8'hBE);
        bus.rx_data = 8'hEF;
        bus.rx_valid = 1'b1;
        tick(1);
        bus.rx_valid = 1'b0;
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        check_reset("s5");
        check("s5_writes", writes, 32'd4);
        // idle bytes ignored, start with a byte discards it, start during DATA ignored
        send(8'hAB);
        send(8'hCD);
        check("s6_idle", {22'd0, bus.busy, bus.words_loaded}, 32'd0);
        bus.start = 1'b1;
        bus.rx_valid = 1'b1;
        bus.rx_data = 8'h05;
        tick(1);
        bus.start = 1'b0;
        bus.rx_valid = 1'b0;
        tick(1);
        check("s6_len0", {31'd0, bus.busy}, 32'd1);
        send(8'h01);
        send(8'h00);
        send(8'h78);
        strt;
        send(8'h56);
        strt;
        send(8'h34);
        push(10'd0, 32'h12345678);
        send(8'h12);
        send(8'h08);
        tick(2);
        check("s6_done", {29'd0, bus.done, bus.error, bus.core_rst}, 32'h4);
        check("s6_wl", {23'd0, bus.words_loaded}, 32'd1);
        check("s6_writes", writes, 32'd5);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
